// File: rtl/corner_pkg.sv
// Shared FIFO entry layout and coordinate widths for the corner list path.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package corner_pkg;

  localparam int MASK_W  = 4;
  localparam int ROW_W   = 10;
  localparam int COL_W   = 9;
  localparam int X_W     = 12;
  localparam int ENTRY_W = 1 + MASK_W + ROW_W + COL_W;

  // One FIFO entry: a window's corner mask with its position, or an EOF marker
  typedef struct packed {
    logic              eof;
    logic [MASK_W-1:0] mask;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
  } entry_t;

  typedef enum logic {
    SER_IDLE,
    SER_EMIT
  } ser_state_t;

  // Index of the lowest set bit; the caller guarantees a non-zero mask
  function automatic logic [1:0] low_idx(input logic [MASK_W-1:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    if (m[0])      idx = 2'd0;
    else if (m[1]) idx = 2'd1;
    else if (m[2]) idx = 2'd2;
    else if (m[3]) idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [2:0] popcount4(input logic [MASK_W-1:0] m);
    return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
  endfunction

endpackage

// File: rtl/corner_fifo.sv
// Generic synchronous FIFO, first-word-fall-through head on pop_dat.
// Latency: a push at edge N is visible on pop_dat / clears empty after edge N.
// Backpressure: caller must not push when full unless popping in the same cycle.
module corner_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 16
) (
  input  logic         core_clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  assign pop_dat = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));

  // Storage write; on push+pop while full this lands in the slot being read out
  always_ff @(posedge core_clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointers and occupancy
  always_ff @(posedge core_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/corner_list.sv
// Turns per-window corner masks into a serial (x,y) beat stream with a frame EOF beat.
// Latency: wv at cycle T into an empty, idle path gives out_valid at T+2.
// Backpressure: out_* held while out_valid & ~out_ready; FIFO buffers, overflow is counted as drops.
module corner_list
  import corner_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int X_OFS = 12,
  parameter int Y_OFS = 4
) (
  input  logic              c,
  input  logic              rst,
  input  logic              fv,
  input  logic              wv,
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  input  logic [MASK_W-1:0] corners,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [X_W-1:0]    out_x,
  output logic [ROW_W-1:0]  out_y,
  output logic              out_eof,
  output logic [15:0]       corner_cnt,
  output logic [15:0]       drop_cnt
);

  logic fv_d1, fv_rise, fv_fall, eof_pend;
  logic data_req, space, eof_push, data_push, data_drop;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  entry_t push_entry, head;

  ser_state_t        state, state_nxt;
  logic [MASK_W-1:0] rem_mask, rem_mask_nxt, src_mask;
  logic [ROW_W-1:0]  rem_row, rem_row_nxt, src_row;
  logic [COL_W-1:0]  rem_col, rem_col_nxt, src_col;
  logic [1:0]        k;
  logic              out_valid_nxt, out_eof_nxt;
  logic [X_W-1:0]    out_x_nxt;
  logic [ROW_W-1:0]  out_y_nxt;
  logic              accept;
  logic [16:0]       drop_sum;

  // Window-centre x: {col,2'b00}+k is simply {col,k}
  function automatic logic [X_W-1:0] pix_x(input logic [COL_W-1:0] cl, input logic [1:0] kk);
    return {1'b0, cl, kk} - X_W'(X_OFS);
  endfunction

  assign fv_rise  = fv & ~fv_d1;
  assign fv_fall  = fv_d1 & ~fv;
  assign data_req = fv & wv & (|corners);
  // A same-cycle pop frees a slot before the push is judged
  assign space     = ~fifo_full | fifo_pop;
  // A pending EOF owns the write port so it never drops and stays ahead of the next frame
  assign eof_push  = eof_pend & space;
  assign data_push = data_req & space & ~eof_pend;
  assign data_drop = data_req & ~data_push;
  assign fifo_push = eof_push | data_push;

  // Build the entry to push: EOF marker carries an all-zero payload
  always_comb begin
    push_entry = '0;
    if (eof_push) begin
      push_entry.eof = 1'b1;
    end else begin
      push_entry.mask = corners;
      push_entry.row  = row;
      push_entry.col  = col;
    end
  end

  corner_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .core_clk (c),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (push_entry),
    .pop      (fifo_pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Frame edge detect and the EOF that waits for a free FIFO slot
  always_ff @(posedge c) begin
    if (rst) begin
      fv_d1    <= 1'b0;
      eof_pend <= 1'b0;
    end else begin
      fv_d1    <= fv;
      eof_pend <= fv_fall | (eof_pend & ~eof_push);
    end
  end

  // Serializer next state: advance whenever the output register is free or being accepted
  always_comb begin
    state_nxt     = state;
    rem_mask_nxt  = rem_mask;
    rem_row_nxt   = rem_row;
    rem_col_nxt   = rem_col;
    out_valid_nxt = out_valid;
    out_eof_nxt   = out_eof;
    out_x_nxt     = out_x;
    out_y_nxt     = out_y;
    fifo_pop      = 1'b0;
    src_mask      = rem_mask;
    src_row       = rem_row;
    src_col       = rem_col;
    k             = 2'd0;
    if (~out_valid | out_ready) begin
      if (state == SER_IDLE) begin
        src_mask = head.mask;
        src_row  = head.row;
        src_col  = head.col;
      end
      k = low_idx(src_mask);
      if (state == SER_EMIT || (!fifo_empty && !head.eof)) begin
        fifo_pop      = (state == SER_IDLE);
        out_valid_nxt = 1'b1;
        out_eof_nxt   = 1'b0;
        out_x_nxt     = pix_x(src_col, k);
        out_y_nxt     = src_row - ROW_W'(Y_OFS);
        rem_mask_nxt  = src_mask & (src_mask - MASK_W'(1));
        rem_row_nxt   = src_row;
        rem_col_nxt   = src_col;
        state_nxt     = (rem_mask_nxt != '0) ? SER_EMIT : SER_IDLE;
      end else if (!fifo_empty) begin
        fifo_pop      = 1'b1;
        out_valid_nxt = 1'b1;
        out_eof_nxt   = 1'b1;
        out_x_nxt     = '0;
        out_y_nxt     = '0;
        rem_mask_nxt  = '0;
        state_nxt     = SER_IDLE;
      end else begin
        out_valid_nxt = 1'b0;
        out_eof_nxt   = 1'b0;
      end
    end
  end

  // Serializer state, working mask and registered output beat
  always_ff @(posedge c) begin
    if (rst) begin
      state     <= SER_IDLE;
      rem_mask  <= '0;
      rem_row   <= '0;
      rem_col   <= '0;
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      state     <= state_nxt;
      rem_mask  <= rem_mask_nxt;
      rem_row   <= rem_row_nxt;
      rem_col   <= rem_col_nxt;
      out_valid <= out_valid_nxt;
      out_eof   <= out_eof_nxt;
      out_x     <= out_x_nxt;
      out_y     <= out_y_nxt;
    end
  end

  assign accept   = out_valid & out_ready;
  assign drop_sum = {1'b0, drop_cnt} + {14'd0, popcount4(corners)};

  // Per-frame saturating counters; frame start clear wins over any increment
  always_ff @(posedge c) begin
    if (rst || fv_rise) begin
      corner_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (accept && !out_eof && corner_cnt != 16'hFFFF) corner_cnt <= corner_cnt + 16'd1;
      if (data_drop) drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_corner_list.sv
module tb_corner_list;

  localparam int DEPTH = 16;

  logic        c = 1'b0;
  logic        rst = 1'b1;
  logic        fv = 1'b0;
  logic        wv = 1'b0;
  logic [9:0]  row = '0;
  logic [8:0]  col = '0;
  logic [3:0]  corners = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_x;
  logic [9:0]  out_y;
  logic        out_eof;
  logic [15:0] corner_cnt;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad = 0;
  int n_extra = 0;
  logic [31:0] sb [$];

  corner_list #(.DEPTH(DEPTH), .X_OFS(12), .Y_OFS(4)) dut (
    .c          (c),
    .rst        (rst),
    .fv         (fv),
    .wv         (wv),
    .row        (row),
    .col        (col),
    .corners    (corners),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_eof    (out_eof),
    .corner_cnt (corner_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 c = ~c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat(input logic eof, input int x, input int y);
    return {9'd0, eof, 12'(x), 10'(y)};
  endfunction

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  // Drive one window for one cycle; expected beats are the set bits, low k first
  task automatic push_mask(input logic [3:0] m, input int r, input int cl, input bit expect_it);
    wv = 1'b1;
    corners = m;
    row = 10'(r);
    col = 9'(cl);
    if (expect_it)
      for (int k = 0; k < 4; k++)
        if (m[k]) sb.push_back(beat(1'b0, cl * 4 + k - 12, r - 4));
    tick();
    wv = 1'b0;
    corners = '0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk({tag, "_timeout"}, 32'(n), 32'(0));
    chk({tag, "_left"}, 32'(sb.size()), 32'(0));
  endtask

  // Scoreboard: every accepted beat must match the oldest expected one
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge c);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_extra++;
        end else begin
          e = sb.pop_front();
          chk("beat", {9'd0, out_eof, out_x, out_y}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    @(negedge c);
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_eof", 32'(out_eof), 32'(0));
    chk("rst_x", 32'(out_x), 32'(0));
    chk("rst_y", 32'(out_y), 32'(0));
    chk("rst_ccnt", 32'(corner_cnt), 32'(0));
    chk("rst_dcnt", 32'(drop_cnt), 32'(0));

    fv = 1'b1;
    tick();

    // Single mask: beats at T+2 and T+3
    out_ready = 1'b1;
    push_mask(4'b1010, 20, 10, 1'b1);
    @(negedge c);
    chk("t1_valid_t1", 32'(out_valid), 32'(0));
    tick();
    @(negedge c);
    chk("t1_valid_t2", 32'(out_valid), 32'(1));
    chk("t1_x0", 32'(out_x), 32'(29));
    chk("t1_y0", 32'(out_y), 32'(16));
    tick();
    @(negedge c);
    chk("t1_valid_t3", 32'(out_valid), 32'(1));
    chk("t1_x1", 32'(out_x), 32'(31));
    tick();
    @(negedge c);
    chk("t1_valid_done", 32'(out_valid), 32'(0));
    chk("t1_ccnt", 32'(corner_cnt), 32'(2));

    // Backpressure: first beat held stable for 5 stalled cycles
    out_ready = 1'b0;
    push_mask(4'b1111, 30, 20, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge c);
      chk("t2_stall_valid", 32'(out_valid), 32'(1));
      chk("t2_stall_x", 32'(out_x), 32'(68));
      chk("t2_stall_y", 32'(out_y), 32'(26));
      tick();
    end
    drain("t2_drain");
    chk("t2_ccnt", 32'(corner_cnt), 32'(6));

    // Overflow: one mask parks in the stalled serializer so the FIFO alone takes the burst
    out_ready = 1'b0;
    push_mask(4'b0011, 40, 30, 1'b1);
    tick();
    tick();
    for (int i = 0; i < DEPTH + 3; i++)
      push_mask(4'b0011, 50 + i, 30, i < DEPTH);
    @(negedge c);
    chk("t3_full", 32'(dut.fifo_full), 32'(1));
    chk("t3_dcnt", 32'(drop_cnt), 32'(6));
    chk("t3_hold_x", 32'(out_x), 32'(108));

    // EOF while full: all queued corners first, then exactly one EOF beat
    fv = 1'b0;
    sb.push_back(beat(1'b1, 0, 0));
    repeat (3) tick();
    drain("t4_drain");
    @(negedge c);
    chk("t4_ccnt", 32'(corner_cnt), 32'(40));
    chk("t4_dcnt", 32'(drop_cnt), 32'(6));
    chk("t4_eof_low", 32'(out_eof), 32'(0));

    // Frame restart with a push in the same cycle
    out_ready = 1'b0;
    fv = 1'b1;
    push_mask(4'b0001, 20, 10, 1'b1);
    @(negedge c);
    chk("t5_ccnt_clr", 32'(corner_cnt), 32'(0));
    chk("t5_dcnt_clr", 32'(drop_cnt), 32'(0));
    drain("t5_drain");
    chk("t5_ccnt", 32'(corner_cnt), 32'(1));

    // Reset mid-burst: pending entries vanish, no EOF follows
    out_ready = 1'b0;
    push_mask(4'b0101, 60, 40, 1'b0);
    push_mask(4'b0011, 61, 40, 1'b0);
    push_mask(4'b1000, 62, 40, 1'b0);
    push_mask(4'b0110, 63, 40, 1'b0);
    tick();
    @(negedge c);
    chk("t6_pre_valid", 32'(out_valid), 32'(1));
    chk("t6_pre_empty", 32'(dut.fifo_empty), 32'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge c);
    chk("t6_valid", 32'(out_valid), 32'(0));
    chk("t6_empty", 32'(dut.fifo_empty), 32'(1));
    out_ready = 1'b1;
    repeat (10) tick();
    chk("t6_eof", 32'(out_eof), 32'(0));

    chk("extra_beats", 32'(n_extra), 32'(0));
    chk("sb_left", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
